// File: rtl/regfile_arbiter_pkg.sv
// rtl/regfile_arbiter_pkg.sv - shared widths and requester indices for the register file arbiter
package regfile_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  // Requester indices; also the encoding of the round-robin priority bit
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_arbiter_rr.sv
// rtl/regfile_arbiter_rr.sv - two-way round-robin grant with a one-bit priority register
module rr_arbiter2
  import regfile_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Requester currently favoured when both are eligible
  logic prio;

  // Grant at most one eligible requester; nothing is granted while in reset
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (req[REQ_A] && req[REQ_B]) begin
        grant[prio] = 1'b1;
      end else if (req[REQ_A]) begin
        grant[REQ_A] = 1'b1;
      end else if (req[REQ_B]) begin
        grant[REQ_B] = 1'b1;
      end
    end
  end

  // After any grant, favour the requester that lost (or did not ask)
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= REQ_A;
    end else if (grant[REQ_A]) begin
      prio <= REQ_B;
    end else if (grant[REQ_B]) begin
      prio <= REQ_A;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - shares one register file port pair between two requesters
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid_a,
  output logic              req_ready_a,
  input  logic              req_we_a,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [DATA_W-1:0] req_wdata_a,
  output logic              resp_valid_a,
  input  logic              resp_ready_a,
  output logic [DATA_W-1:0] resp_rdata_a,

  input  logic              req_valid_b,
  output logic              req_ready_b,
  input  logic              req_we_b,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata_b,
  output logic              resp_valid_b,
  input  logic              resp_ready_b,
  output logic [DATA_W-1:0] resp_rdata_b,

  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] read_reg1,
  input  logic [DATA_W-1:0] read_data1
);

  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] resp_next;

  // A requester may compete only if its response slot is empty or draining this cycle
  assign eligible[REQ_A] = req_valid_a && (!resp_valid_a || resp_ready_a);
  assign eligible[REQ_B] = req_valid_b && (!resp_valid_b || resp_ready_b);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (eligible),
    .grant (grant)
  );

  assign req_ready_a = grant[REQ_A];
  assign req_ready_b = grant[REQ_B];
  assign accept      = |grant;

  assign sel_we    = grant[REQ_B] ? req_we_b    : req_we_a;
  assign sel_addr  = grant[REQ_B] ? req_addr_b  : req_addr_a;
  assign sel_wdata = grant[REQ_B] ? req_wdata_b : req_wdata_a;

  // Reads return register data; writes are acknowledged with zero data
  assign resp_next = sel_we ? '0 : read_data1;

  // Drive the register file ports only for the accepted request; R0 is never written
  always_comb begin
    RegWrite   = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = '0;
    if (accept) begin
      if (sel_we) begin
        RegWrite   = (sel_addr != '0);
        write_reg  = sel_addr;
        write_data = sel_wdata;
      end else begin
        read_reg1 = sel_addr;
      end
    end
  end

  // Response slot a: load on acceptance, hold until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_a <= 1'b0;
      resp_rdata_a <= '0;
    end else if (grant[REQ_A]) begin
      resp_valid_a <= 1'b1;
      resp_rdata_a <= resp_next;
    end else if (resp_ready_a) begin
      resp_valid_a <= 1'b0;
    end
  end

  // Response slot b: load on acceptance, hold until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_b <= 1'b0;
      resp_rdata_b <= '0;
    end else if (grant[REQ_B]) begin
      resp_valid_b <= 1'b1;
      resp_rdata_b <= resp_next;
    end else if (resp_ready_b) begin
      resp_valid_b <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed bench for regfile_arbiter with a behavioural register file
module tb_regfile_arbiter;

  logic        clk;
  logic        rst;
  logic        req_valid_a, req_ready_a, req_we_a;
  logic [2:0]  req_addr_a;
  logic [15:0] req_wdata_a;
  logic        resp_valid_a, resp_ready_a;
  logic [15:0] resp_rdata_a;
  logic        req_valid_b, req_ready_b, req_we_b;
  logic [2:0]  req_addr_b;
  logic [15:0] req_wdata_b;
  logic        resp_valid_b, resp_ready_b;
  logic [15:0] resp_rdata_b;
  logic        RegWrite;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic [2:0]  read_reg1;
  logic [15:0] read_data1;

  logic [15:0] regs [8];

  int n_checks = 0;
  int n_pass   = 0;

  regfile_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_a  (req_valid_a),
    .req_ready_a  (req_ready_a),
    .req_we_a     (req_we_a),
    .req_addr_a   (req_addr_a),
    .req_wdata_a  (req_wdata_a),
    .resp_valid_a (resp_valid_a),
    .resp_ready_a (resp_ready_a),
    .resp_rdata_a (resp_rdata_a),
    .req_valid_b  (req_valid_b),
    .req_ready_b  (req_ready_b),
    .req_we_b     (req_we_b),
    .req_addr_b   (req_addr_b),
    .req_wdata_b  (req_wdata_b),
    .resp_valid_b (resp_valid_b),
    .resp_ready_b (resp_ready_b),
    .resp_rdata_b (resp_rdata_b),
    .RegWrite     (RegWrite),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .read_reg1    (read_reg1),
    .read_data1   (read_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous write, combinational read
  always @(posedge clk) begin
    if (RegWrite) regs[write_reg] <= write_data;
  end
  assign read_data1 = regs[read_reg1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic we, input logic [2:0] addr, input logic [15:0] wd);
    req_valid_a = v; req_we_a = we; req_addr_a = addr; req_wdata_a = wd;
  endtask

  task automatic drive_b(input logic v, input logic we, input logic [2:0] addr, input logic [15:0] wd);
    req_valid_b = v; req_we_b = we; req_addr_b = addr; req_wdata_b = wd;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    regs[3] = 16'h00A5;

    rst = 1'b1;
    resp_ready_a = 1'b1;
    resp_ready_b = 1'b1;
    drive_a(1'b1, 1'b0, 3'd3, 16'h0);
    drive_b(1'b1, 1'b0, 3'd3, 16'h0);

    // Reset: nothing granted, slots cleared
    tick;
    @(negedge clk);
    check("rst_ready_a", req_ready_a, 0);
    check("rst_ready_b", req_ready_b, 0);
    check("rst_regwrite", RegWrite, 0);
    check("rst_resp_valid_a", resp_valid_a, 0);
    check("rst_resp_valid_b", resp_valid_b, 0);
    check("rst_rdata_a", resp_rdata_a, 0);
    tick;
    rst = 1'b0;

    // Both read R3: a first, then b
    @(negedge clk);
    check("t1_c1_ready_a", req_ready_a, 1);
    check("t1_c1_ready_b", req_ready_b, 0);
    check("t1_c1_read_reg1", read_reg1, 3);
    tick;
    drive_a(1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    check("t1_c2_ready_b", req_ready_b, 1);
    check("t1_c2_resp_valid_a", resp_valid_a, 1);
    check("t1_c2_rdata_a", resp_rdata_a, 16'h00A5);
    tick;
    drive_b(1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    check("t1_c3_resp_valid_b", resp_valid_b, 1);
    check("t1_c3_rdata_b", resp_rdata_b, 16'h00A5);
    check("t1_c3_resp_valid_a", resp_valid_a, 0);
    tick;

    // a writes R5 then reads it back
    drive_a(1'b1, 1'b1, 3'd5, 16'h1234);
    @(negedge clk);
    check("t2_wr_ready_a", req_ready_a, 1);
    check("t2_wr_regwrite", RegWrite, 1);
    check("t2_wr_write_reg", write_reg, 5);
    check("t2_wr_write_data", write_data, 16'h1234);
    tick;
    drive_a(1'b1, 1'b0, 3'd5, 16'h0);
    @(negedge clk);
    check("t2_rd_regwrite", RegWrite, 0);
    check("t2_rd_ready_a", req_ready_a, 1);
    check("t2_ack_valid_a", resp_valid_a, 1);
    check("t2_ack_rdata_a", resp_rdata_a, 0);
    tick;
    drive_a(1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    check("t2_resp_valid_a", resp_valid_a, 1);
    check("t2_rdata_a", resp_rdata_a, 16'h1234);
    check("t2_idle_write_reg", write_reg, 0);
    check("t2_idle_read_reg1", read_reg1, 0);
    tick;

    // b writes R0: acknowledged but never written
    drive_b(1'b1, 1'b1, 3'd0, 16'hFFFF);
    @(negedge clk);
    check("t3_wr_ready_b", req_ready_b, 1);
    check("t3_wr_regwrite", RegWrite, 0);
    tick;
    drive_b(1'b1, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    check("t3_ack_valid_b", resp_valid_b, 1);
    check("t3_rd_ready_b", req_ready_b, 1);
    tick;
    drive_b(1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    check("t3_r0_rdata_b", resp_rdata_b, 0);
    check("t3_r0_model", regs[0], 0);
    tick;

    // a back-pressured on its response while b streams
    resp_ready_a = 1'b0;
    drive_a(1'b1, 1'b0, 3'd3, 16'h0);
    drive_b(1'b1, 1'b0, 3'd5, 16'h0);
    @(negedge clk);
    check("t4_k0_ready_a", req_ready_a, 1);
    check("t4_k0_ready_b", req_ready_b, 0);
    tick;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("t4_k%0d_ready_a", k), req_ready_a, 0);
      check($sformatf("t4_k%0d_ready_b", k), req_ready_b, 1);
      check($sformatf("t4_k%0d_valid_a", k), resp_valid_a, 1);
      check($sformatf("t4_k%0d_rdata_a", k), resp_rdata_a, 16'h00A5);
      if (k > 1) begin
        check($sformatf("t4_k%0d_valid_b", k), resp_valid_b, 1);
        check($sformatf("t4_k%0d_rdata_b", k), resp_rdata_b, 16'h1234);
      end
      tick;
    end
    resp_ready_a = 1'b1;
    @(negedge clk);
    check("t4_k4_ready_a", req_ready_a, 1);
    check("t4_k4_ready_b", req_ready_b, 0);
    tick;
    drive_a(1'b0, 1'b0, 3'd0, 16'h0);
    drive_b(1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    check("t4_k5_valid_a", resp_valid_a, 1);
    check("t4_k5_rdata_a", resp_rdata_a, 16'h00A5);
    tick;

    // Reset right after an accepted write
    drive_a(1'b1, 1'b1, 3'd6, 16'h0077);
    @(negedge clk);
    check("t5_wr_regwrite", RegWrite, 1);
    tick;
    rst = 1'b1;
    drive_b(1'b1, 1'b0, 3'd3, 16'h0);
    @(negedge clk);
    check("t5_rst_ready_a", req_ready_a, 0);
    check("t5_rst_ready_b", req_ready_b, 0);
    check("t5_rst_regwrite", RegWrite, 0);
    tick;
    rst = 1'b0;
    drive_a(1'b1, 1'b0, 3'd3, 16'h0);
    @(negedge clk);
    check("t5_post_valid_a", resp_valid_a, 0);
    check("t5_post_rdata_a", resp_rdata_a, 0);
    check("t5_post_rdata_b", resp_rdata_b, 0);
    check("t5_post_prio_a", req_ready_a, 1);
    check("t5_post_prio_b", req_ready_b, 0);
    check("t5_r6_kept", regs[6], 16'h0077);
    tick;
    drive_a(1'b0, 1'b0, 3'd0, 16'h0);
    drive_b(1'b0, 1'b0, 3'd0, 16'h0);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, register data width in bits.
REQ-002 Parameter: ADDR_W, default 3, register address width in bits (8 registers).
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Ports, per requester n in {a,b}: req_valid_n  input  1, request present.
REQ-006 Ports: req_ready_n  output  1  request accepted this cycle when high together with req_valid_n.
REQ-007 Ports: req_we_n  input  1  1 = write, 0 = read.
REQ-008 Ports: req_addr_n  input  ADDR_W, register index; req_wdata_n  input  DATA_W, write data.
REQ-009 Ports: resp_valid_n  output  1; resp_ready_n  input  1; resp_rdata_n  output  DATA_W, read result (0 for write acks).
REQ-010 Ports to register file: RegWrite  output  1; write_reg  output  ADDR_W; write_data  output  DATA_W; read_reg1  output  ADDR_W; read_data1  input  DATA_W (combinational read).

Function
REQ-011 At most one request SHALL be accepted per cycle; acceptance = req_valid_n && req_ready_n.
REQ-012 Requester n is eligible when req_valid_n && (!resp_valid_n || resp_ready_n).
REQ-013 Arbitration SHALL be round-robin via a 1-bit priority register; with both eligible, the prioritized one wins; with one eligible, it wins regardless of priority.
REQ-014 On every acceptance the priority register SHALL point to the non-winning requester next cycle; no acceptance leaves it unchanged.
REQ-015 req_ready_n SHALL be high only for the granted requester, combinationally in the accepting cycle.
REQ-016 Accepted write: RegWrite=1, write_reg=req_addr, write_data=req_wdata in the same cycle; register updated at that clock edge.
REQ-017 Accepted write to address 0 SHALL keep RegWrite=0 and still produce an ack response.
REQ-018 Accepted read: read_reg1=req_addr in the same cycle; read_data1 captured into resp_rdata_n at that edge.
REQ-019 Response latency SHALL be exactly 1 cycle: resp_valid_n rises the cycle after acceptance.
REQ-020 resp_valid_n/resp_rdata_n SHALL hold stable until resp_ready_n; a same-cycle handshake plus new acceptance reloads them without a bubble.
REQ-021 Without acceptance, RegWrite SHALL be 0; write_reg, write_data, read_reg1 are don't-care but SHALL be driven to 0.
REQ-022 Read following a write to the same address in the next cycle SHALL return the new value (no forwarding needed; write precedes read).
REQ-023 Each requester has at most one outstanding response; a full, unconsumed response slot blocks only that requester.

Reset
REQ-024 While rst is high at a clock edge: priority -> requester a; resp_valid_a/b -> 0; resp_rdata_a/b -> 0.
REQ-025 During rst, req_ready_a/b and RegWrite SHALL be 0; in-flight responses are discarded; register file contents untouched.

Structure
REQ-026 Shared package holds DATA_W/ADDR_W defaults and requester index constants REQ_A=0, REQ_B=1.
REQ-027 One sub-module natural: rr_arbiter2 (2-way round-robin grant + priority register); response slots stay in the top.

Verification
REQ-028 Both read R3 (=16'h00A5) same cycle after reset -> a granted cycle 1, b cycle 2; each resp_rdata=16'h00A5 one cycle later.
REQ-029 a writes R5=16'h1234, then reads R5 next cycle -> RegWrite pulse one cycle; resp_rdata_a=16'h1234.
REQ-030 b writes R0=16'hFFFF -> RegWrite stays 0; ack resp_valid_b next cycle; later read R0 returns 0.
REQ-031 resp_ready_a held low 3 cycles with a continuously requesting -> req_ready_a low, b accepted every cycle meanwhile; a resumes after handshake.
REQ-032 rst asserted cycle after acceptance -> resp_valid clears, priority returns to a, no RegWrite during reset.
